// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and memory bus of the
// two-port memory arbiter.
//   slave  - the arbiter side
//   master - the core/memory side
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed memory between the instruction
// fetch path and the load/store path. One access per IDLE->ACCESS->RESP
// round trip (3 cycles). All outputs are registered.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   - ties go to the side that did not win the last grant
//               (first tie after reset goes to fetch)
//   undefined - ties always go to the data side
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          owner_d;   // 1 = data side owns the current access
  logic          grant_d;   // data side wins the pending arbitration
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          mem_we_q;
  logic          if_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          busy_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic          last_d;    // 1 = last grant went to the data side

  // Tie goes to whoever lost the previous grant.
  always_comb begin
    grant_d = bus.d_req && (!bus.if_req || !last_d);
  end
`else
  // Data side has fixed priority over fetch.
  always_comb begin
    grant_d = bus.d_req;
  end
`endif

  // Arbitration FSM; mem_we doubles as the latched write flag while in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            owner_d    <= grant_d;
            mem_addr_q <= grant_d ? bus.d_addr : bus.if_addr;
            if (grant_d) mem_wdata_q <= bus.d_wdata;
            mem_we_q   <= grant_d && bus.d_we;
            busy_q     <= 1'b1;
            state      <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_d     <= grant_d;
`endif
          end
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
          if (!mem_we_q) begin
            if (owner_d) d_rdata_q  <= bus.mem_rdata;
            else         if_rdata_q <= bus.mem_rdata;
          end
          d_ack_q  <= owner_d;
          if_ack_q <= !owner_d;
          state    <= RESP;
        end
        RESP: begin
          d_ack_q  <= 1'b0;
          if_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter. Each table
// row is one clock: inputs driven before the edge, outputs checked 1ns after.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory array environment: combinational read, synchronous write.
  logic [15:0] mem [0:65535];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dd;
    logic        e_ia;
    logic        e_da;
    logic        e_we;
    logic        e_busy;
    logic [15:0] e_ma;
    logic [15:0] e_ir;
    logic [15:0] e_dr;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic ir, logic [15:0] ia, logic dr, logic dw,
                              logic [15:0] da, logic [15:0] dd,
                              logic e_ia, logic e_da, logic e_we, logic e_busy,
                              logic [15:0] e_ma, logic [15:0] e_ir, logic [15:0] e_dr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.e_ia = e_ia; v.e_da = e_da; v.e_we = e_we; v.e_busy = e_busy;
    v.e_ma = e_ma; v.e_ir = e_ir; v.e_dr = e_dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                       input logic dw, input logic [15:0] da, input logic [15:0] dd);
    bus.if_req = ir; bus.if_addr = ia;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
  endtask

  initial begin
    logic [15:0] ir_after_tie;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    mem[16'h0000] = 16'h00FF;
    mem[16'h0010] = 16'h1111;
    mem[16'h0020] = 16'h2222;
    drive(0, 0, 0, 0, 0, 0);

    // fetch alone
    tbl.push_back(mk(1,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,1, 16'h0000,16'h0000,16'h0000));
    tbl.push_back(mk(1,16'h0000,0,0,16'h0000,16'h0000, 1,0,0,1, 16'h0000,16'h00FF,16'h0000));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0, 16'h0000,16'h00FF,16'h0000));
    // data write
    tbl.push_back(mk(0,16'h0000,1,1,16'h1234,16'hBEEF, 0,0,1,1, 16'h1234,16'h00FF,16'h0000));
    tbl.push_back(mk(0,16'h0000,1,1,16'h1234,16'hBEEF, 0,1,0,1, 16'h1234,16'h00FF,16'h0000));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0, 16'h1234,16'h00FF,16'h0000));
    // data read back
    tbl.push_back(mk(0,16'h0000,1,0,16'h1234,16'h0000, 0,0,0,1, 16'h1234,16'h00FF,16'h0000));
    tbl.push_back(mk(0,16'h0000,1,0,16'h1234,16'h0000, 0,1,0,1, 16'h1234,16'h00FF,16'hBEEF));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0, 16'h1234,16'h00FF,16'hBEEF));
    // both requests held: fetch 0x0010, data read 0x0020
`ifdef ARB_ROUND_ROBIN_EN
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,1, 16'h0010,16'h00FF,16'hBEEF));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 1,0,0,1, 16'h0010,16'h1111,16'hBEEF));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,0, 16'h0010,16'h1111,16'hBEEF));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,1, 16'h0020,16'h1111,16'hBEEF));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,1,0,1, 16'h0020,16'h1111,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,0, 16'h0020,16'h1111,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,1, 16'h0010,16'h1111,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 1,0,0,1, 16'h0010,16'h1111,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,0, 16'h0010,16'h1111,16'h2222));
    ir_after_tie = 16'h1111;
`else
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,1, 16'h0020,16'h00FF,16'hBEEF));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,1,0,1, 16'h0020,16'h00FF,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,0, 16'h0020,16'h00FF,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,1, 16'h0020,16'h00FF,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,1,0,1, 16'h0020,16'h00FF,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,0, 16'h0020,16'h00FF,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,1, 16'h0020,16'h00FF,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,1,0,1, 16'h0020,16'h00FF,16'h2222));
    tbl.push_back(mk(1,16'h0010,1,0,16'h0020,16'h0000, 0,0,0,0, 16'h0020,16'h00FF,16'h2222));
    ir_after_tie = 16'h00FF;
`endif
    // d_req drops, fetch alone is served
    tbl.push_back(mk(1,16'h0010,0,0,16'h0000,16'h0000, 0,0,0,1, 16'h0010,ir_after_tie,16'h2222));
    tbl.push_back(mk(1,16'h0010,0,0,16'h0000,16'h0000, 1,0,0,1, 16'h0010,16'h1111,16'h2222));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0, 16'h0010,16'h1111,16'h2222));
    // fetch request pulsed during a data access is dropped
    tbl.push_back(mk(0,16'h0000,1,0,16'h1234,16'h0000, 0,0,0,1, 16'h1234,16'h1111,16'h2222));
    tbl.push_back(mk(1,16'h0055,1,0,16'h1234,16'h0000, 0,1,0,1, 16'h1234,16'h1111,16'hBEEF));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0, 16'h1234,16'h1111,16'hBEEF));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0, 16'h1234,16'h1111,16'hBEEF));
    // back-to-back data reads with req held through the ack
    tbl.push_back(mk(0,16'h0000,1,0,16'h0020,16'h0000, 0,0,0,1, 16'h0020,16'h1111,16'hBEEF));
    tbl.push_back(mk(0,16'h0000,1,0,16'h0020,16'h0000, 0,1,0,1, 16'h0020,16'h1111,16'h2222));
    tbl.push_back(mk(0,16'h0000,1,0,16'h0020,16'h0000, 0,0,0,0, 16'h0020,16'h1111,16'h2222));
    tbl.push_back(mk(0,16'h0000,1,0,16'h0020,16'h0000, 0,0,0,1, 16'h0020,16'h1111,16'h2222));
    tbl.push_back(mk(0,16'h0000,1,0,16'h0020,16'h0000, 0,1,0,1, 16'h0020,16'h1111,16'h2222));
    tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0, 16'h0020,16'h1111,16'h2222));

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_we", 16'(bus.mem_we), 16'h0);
    chk("rst_ifack", 16'(bus.if_ack), 16'h0);
    chk("rst_dack", 16'(bus.d_ack), 16'h0);
    chk("rst_maddr", bus.mem_addr, 16'h0);
    chk("rst_mwdata", bus.mem_wdata, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_if_ack", i), 16'(bus.if_ack), 16'(tbl[i].e_ia));
      chk($sformatf("r%0d_d_ack", i), 16'(bus.d_ack), 16'(tbl[i].e_da));
      chk($sformatf("r%0d_mem_we", i), 16'(bus.mem_we), 16'(tbl[i].e_we));
      chk($sformatf("r%0d_busy", i), 16'(bus.busy), 16'(tbl[i].e_busy));
      chk($sformatf("r%0d_mem_addr", i), bus.mem_addr, tbl[i].e_ma);
      chk($sformatf("r%0d_if_rdata", i), bus.if_rdata, tbl[i].e_ir);
      chk($sformatf("r%0d_d_rdata", i), bus.d_rdata, tbl[i].e_dr);
    end

    // reset asserted in the middle of a write's ACCESS cycle
    drive(0, 16'h0000, 1, 1, 16'h0040, 16'h5A5A);
    @(posedge clk);
    #1;
    chk("mid_we_before", 16'(bus.mem_we), 16'h1);
    chk("mid_addr_before", bus.mem_addr, 16'h0040);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_we", 16'(bus.mem_we), 16'h0);
    chk("mid_busy", 16'(bus.busy), 16'h0);
    chk("mid_dack", 16'(bus.d_ack), 16'h0);
    chk("mid_maddr", bus.mem_addr, 16'h0);
    chk("mid_mwdata", bus.mem_wdata, 16'h0);
    chk("mid_irdata", bus.if_rdata, 16'h0);
    chk("mid_drdata", bus.d_rdata, 16'h0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_dack", c), 16'(bus.d_ack), 16'h0);
      chk($sformatf("post_rst%0d_busy", c), 16'(bus.busy), 16'h0);
    end
    chk("mid_no_write", mem[16'h0040], 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
